// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial feeder for the "010" detector, one data bit per enabled clock.
module serial_bit_source #(
    parameter int   WIDTH     = 8,
    parameter bit   LSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             out_valid,
    output logic             word_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] shifter, hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             accept, load_in, load_hold, advance, hold_set;

    assign in_ready   = ~hold_full;
    assign accept     = in_valid & ~hold_full;
    assign out_valid  = (state == SHIFT);
    // The outgoing bit always sits at the shifter's exit end, so no counter-indexed mux is needed.
    assign serial_out = out_valid ? (LSB_FIRST ? shifter[0] : shifter[WIDTH-1]) : IDLE_BIT;
    assign word_done  = (state == SHIFT) && shift_en && (cnt == LAST);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_in    = 1'b0;
        load_hold  = 1'b0;
        advance    = 1'b0;
        hold_set   = 1'b0;
        if (state == IDLE) begin
            load_in    = accept;
            next_state = accept ? SHIFT : IDLE;
        end else begin
            if (word_done) begin
                load_hold  = hold_full;
                load_in    = ~hold_full & accept;
                next_state = (hold_full | accept) ? SHIFT : IDLE;
            end else begin
                advance = shift_en;
            end
            hold_set = accept & ~load_in;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            if (load_in)        shifter <= data_in;
            else if (load_hold) shifter <= hold;
            else if (advance)   shifter <= LSB_FIRST ? (shifter >> 1) : (shifter << 1);
            if (load_in || load_hold) cnt <= '0;
            else if (advance)         cnt <= cnt + CW'(1);
            if (hold_set) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: directed checks of serialization, streaming, backpressure, stall and reset.
module tb_serial_bit_source;
    logic       clock = 1'b0;
    logic       reset_L;
    logic [7:0] data_in, data_in2;
    logic       in_valid, in_valid2, shift_en, shift_en2;
    logic       in_ready, serial_out, out_valid, word_done;
    logic       in_ready2, serial_out2, out_valid2, word_done2;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          f_cnt;
    logic [2:0]  hist;
    logic [7:0]  pat8;
    logic [10:0] pat11;
    logic [15:0] pat16;
    logic [23:0] pat24;

    always #5 clock = ~clock;

    serial_bit_source u_msb (
        .clock(clock), .reset_L(reset_L), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .shift_en(shift_en), .serial_out(serial_out),
        .out_valid(out_valid), .word_done(word_done)
    );

    serial_bit_source #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_lsb (
        .clock(clock), .reset_L(reset_L), .data_in(data_in2), .in_valid(in_valid2),
        .in_ready(in_ready2), .shift_en(shift_en2), .serial_out(serial_out2),
        .out_valid(out_valid2), .word_done(word_done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_serial"}, serial_out, 1'b1);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_done"}, word_done, 1'b0);
    endtask

    initial begin
        reset_L = 1'b0; data_in = '0; in_valid = 1'b0; shift_en = 1'b1;
        data_in2 = '0; in_valid2 = 1'b0; shift_en2 = 1'b1;
        #12;
        check_idle("rst");
        check("rst_ready", in_ready, 1'b1);
        check("rst_lsb_serial", serial_out2, 1'b0);
        check("rst_lsb_valid", out_valid2, 1'b0);
        reset_L = 1'b1;

        // Single word A5, MSB first, with a behavioural 010 detector on the line.
        data_in = 8'hA5; in_valid = 1'b1; tick;
        in_valid = 1'b0; data_in = 8'h00;
        pat8 = 8'hA5; f_cnt = 0; hist = 3'b111;
        for (int i = 0; i < 8; i++) begin
            check("t1_bit", serial_out, pat8[7-i]);
            check("t1_valid", out_valid, 1'b1);
            check("t1_done", word_done, i == 7);
            hist = {hist[1:0], serial_out};
            if (hist == 3'b010) f_cnt++;
            tick;
        end
        check("t1_f_count", f_cnt, 2);
        check_idle("t1_idle");

        // Back-to-back 0F then F0: second word goes to hold, no gap.
        data_in = 8'h0F; in_valid = 1'b1; tick;
        data_in = 8'hF0;
        pat16 = 16'h0FF0;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) begin
                in_valid = 1'b0;
                check("t2_ready_hold", in_ready, 1'b0);
            end
            check("t2_bit", serial_out, pat16[15-i]);
            check("t2_valid", out_valid, 1'b1);
            check("t2_done", word_done, (i == 7) || (i == 15));
            tick;
        end
        check_idle("t2_idle");

        // Three words offered continuously: ready drops while hold is full.
        data_in = 8'h11; in_valid = 1'b1; tick;
        pat24 = 24'h112233;
        for (int i = 0; i < 24; i++) begin
            check("t3_bit", serial_out, pat24[23-i]);
            check("t3_valid", out_valid, 1'b1);
            check("t3_ready", in_ready, (i == 0) || (i == 8) || (i >= 16));
            check("t3_done", word_done, (i % 8) == 7);
            if (i == 0) data_in = 8'h22;
            if (i == 1) data_in = 8'h33;
            if (i == 9) in_valid = 1'b0;
            tick;
        end
        in_valid = 1'b0;
        check_idle("t3_idle");

        // Stall for three cycles while bit 2 of A5 is on the line.
        data_in = 8'hA5; in_valid = 1'b1; tick;
        in_valid = 1'b0;
        pat11 = 11'b10111100101;
        for (int c = 0; c < 11; c++) begin
            shift_en = !(c >= 2 && c <= 4);
            #1;
            check("t4_bit", serial_out, pat11[10-c]);
            check("t4_valid", out_valid, 1'b1);
            check("t4_done", word_done, c == 10);
            tick;
        end
        shift_en = 1'b1;
        check_idle("t4_idle");

        // Reset after four bits of 3C while 55 waits in hold.
        data_in = 8'h3C; in_valid = 1'b1; tick;
        data_in = 8'h55;
        pat8 = 8'h3C;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) in_valid = 1'b0;
            check("t5_bit", serial_out, pat8[7-c]);
            tick;
        end
        check("t5_ready_full", in_ready, 1'b0);
        reset_L = 1'b0; #1;
        check_idle("t5_rst");
        check("t5_rst_ready", in_ready, 1'b1);
        #2; reset_L = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick;
            check("t5_quiet_valid", out_valid, 1'b0);
            check("t5_quiet_serial", serial_out, 1'b1);
        end
        data_in = 8'hC3; in_valid = 1'b1; tick;
        in_valid = 1'b0;
        pat8 = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            check("t5_new_bit", serial_out, pat8[7-i]);
            check("t5_new_valid", out_valid, 1'b1);
            tick;
        end
        check_idle("t5_idle");

        // LSB-first instance with idle level 0.
        data_in2 = 8'h01; in_valid2 = 1'b1; tick;
        in_valid2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t6_bit", serial_out2, i == 0);
            check("t6_valid", out_valid2, 1'b1);
            check("t6_done", word_done2, i == 7);
            tick;
        end
        check("t6_idle_serial", serial_out2, 1'b0);
        check("t6_idle_valid", out_valid2, 1'b0);
        check("t6_idle_ready", in_ready2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-to-serial stage that feeds the serial `a` input of the team's "010" sequence-detector FSM, one bit per enabled clock.
- Accepts WIDTH-bit words over a valid/ready handshake into a one-entry holding buffer plus a shift register.
- Back-to-back words stream with no idle gap.
- Idle line level is programmable, so the detector sees a defined value between words.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = shift out MSB first, 1 = shift out LSB first.
- IDLE_BIT, 1'b1, value driven on serial_out while no word is shifting.

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word to serialize.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  advance one bit at this posedge; pacing/stall control.
- serial_out  output  1  serial bit stream; connects to the detector's `a` input.
- out_valid  output  1  serial_out carries a data bit (not idle fill).
- word_done  output  1  last bit of the current word is being consumed this cycle.

Behaviour:
- Reset (async, reset_L=0):
  - state=IDLE, hold buffer empty, bit counter=0.
  - serial_out=IDLE_BIT, out_valid=0, in_ready=1, word_done=0.
  - Any partially shifted word and any held word are discarded; no partial output after release.
- Accept: a word is transferred at a posedge where in_valid=1 and in_ready=1.
- in_ready = ~hold_full. It is a function of registered state only, with no combinational path from in_valid.
- State IDLE:
  - serial_out=IDLE_BIT, out_valid=0.
  - An accepted word loads directly into the shifter; state becomes SHIFT and counter=0.
  - The first bit is on serial_out in the cycle after acceptance (latency 1).
  - shift_en is ignored in IDLE.
- State SHIFT:
  - out_valid=1; serial_out = bit[counter] (LSB_FIRST=1) or bit[WIDTH-1-counter] (LSB_FIRST=0).
  - serial_out is driven from registers only.
  - shift_en=0: hold serial_out and counter unchanged (stall); accepts into the hold buffer are still allowed.
  - shift_en=1 and counter<WIDTH-1: counter+1.
  - shift_en=1 and counter=WIDTH-1: word_done=1 this cycle (combinational from counter, state and shift_en). The next word is then chosen by priority:
    - (a) hold buffer full: load hold into the shifter, mark hold empty, counter=0, stay SHIFT.
    - (b) hold empty and a word accepted this same edge: load it directly into the shifter, stay SHIFT, no gap.
    - (c) otherwise: go to IDLE, serial_out returns to IDLE_BIT the next cycle.
  - An accept while in SHIFT that is not consumed by case (b) writes the hold buffer (hold_full=1).
- Simultaneous events:
  - Accept while hold is full is impossible, because in_ready=0.
  - A hold drain (case a) and a new accept cannot coincide on one edge; in_ready was 0 that cycle.
- Throughput: with shift_en held at 1, sustained rate is one word per WIDTH cycles, with zero idle cycles between words.
- Counter width is clog2(WIDTH). The counter never exceeds WIDTH-1; wrap occurs only through a reload.
- Data is captured on acceptance. data_in may change freely afterwards.

Test Plan:
- Reset, WIDTH=8, LSB_FIRST=0: send 8'hA5 with shift_en=1 -> from the cycle after acceptance, serial_out = 1,0,1,0,0,1,0,1, out_valid=1 for exactly 8 cycles, word_done on the 8th, then serial_out=1 (IDLE_BIT) and out_valid=0. Downstream detector f asserts twice.
- Back-to-back: offer 8'h0F then 8'hF0 immediately; second accepted into hold while first shifts -> 16 consecutive valid bits 00001111_11110000 with no gap, word_done at cycles 8 and 16.
- Backpressure: offer three words back-to-back -> in_ready drops to 0 once hold is full. The third word is accepted on the edge after the first word's word_done. Output order is preserved and no word is lost.
- Stall: during 8'hA5, hold shift_en=0 for 3 cycles after bit 2 -> serial_out holds 1 for 3 extra cycles, then the sequence resumes unchanged. Total valid cycles = 11.
- Reset mid-word: assert reset_L=0 after 4 bits of 8'h3C with hold full -> immediately serial_out=IDLE_BIT, out_valid=0, in_ready=1. After release, no residual bits appear until a new word is sent.
- LSB_FIRST=1, IDLE_BIT=0: send 8'h01 -> serial_out = 1,0,0,0,0,0,0,0, then 0 while idle, out_valid deasserted.
